sync_debounce: RTL and testbench
================================

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, number of independent channels (>=1).
REQ-002 The block SHALL have parameter STAGES, default 2, synchroniser flop depth per channel (>=2).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive cycles a new value must persist before acceptance (>=1).
REQ-004 The block SHALL have parameter RESET_VAL, default 0 (WIDTH bits), per-channel reset level.
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all state is clocked on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit, reset, synchronous and active-high.
REQ-007 The block SHALL have port async_i, input, WIDTH bits, asynchronous level inputs.
REQ-008 The block SHALL have port sync_o, output, WIDTH bits, synchronised and filtered level.
REQ-009 The block SHALL have port rise_o, output, WIDTH bits, one-cycle pulse on sync_o 0->1 per channel.
REQ-010 The block SHALL have port fall_o, output, WIDTH bits, one-cycle pulse on sync_o 1->0 per channel.

Function
REQ-011 Each channel SHALL sample async_i[n] into a STAGES-deep flop chain; the last stage is the synchronised value s[n].
REQ-012 Channels SHALL be fully independent; no cross-channel state sharing.
REQ-013 With filtering, each channel SHALL hold accepted value q[n] (driven on sync_o[n]) and counter cnt[n] of width clog2(DEBOUNCE_CYCLES+1).
REQ-014 If s[n]==q[n], cnt[n] SHALL load 0 on the next edge.
REQ-015 If s[n]!=q[n] and cnt[n]<DEBOUNCE_CYCLES-1, cnt[n] SHALL increment.
REQ-016 If s[n]!=q[n] and cnt[n]==DEBOUNCE_CYCLES-1, q[n] SHALL load s[n] and cnt[n] SHALL load 0 on the same edge.
REQ-017 A change on async_i[n] stable from the first sampling edge SHALL appear on sync_o[n] exactly STAGES+DEBOUNCE_CYCLES edges later.
REQ-018 A pulse on s[n] lasting fewer than DEBOUNCE_CYCLES cycles SHALL leave sync_o[n] unchanged and return cnt[n] to 0.
REQ-019 cnt[n] SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-020 The block SHALL hold a one-cycle-delayed copy p[n] of sync_o[n]; rise_o[n]=sync_o[n]&~p[n] and fall_o[n]=~sync_o[n]&p[n], combinational.
REQ-021 rise_o[n] and fall_o[n] SHALL each be high for exactly one cycle per transition and never simultaneously.
REQ-022 Simultaneous transitions on multiple channels SHALL each produce their own pulse in the same cycle.

Reset
REQ-023 While rst_i is high at a rising edge, all synchroniser stages, q and p SHALL load RESET_VAL and all cnt SHALL load 0.
REQ-024 sync_o SHALL equal RESET_VAL and rise_o/fall_o SHALL be 0 in the cycle after any reset edge.
REQ-025 Reset asserted mid-debounce SHALL discard the pending count; no transition is accepted from pre-reset samples.
REQ-026 No output SHALL change asynchronously to clk_i on rst_i.

Configuration
REQ-027 Macro SYNC_DEBOUNCE_FILTER_EN SHALL compile in REQ-013 to REQ-019 (counters and q registers).
REQ-028 Without SYNC_DEBOUNCE_FILTER_EN, sync_o SHALL equal s directly (latency STAGES edges), DEBOUNCE_CYCLES SHALL be ignored, and no counter logic SHALL be generated; edge pulses and reset behaviour are unchanged.

Verification (WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=4'b0000, filter enabled unless stated)
REQ-029 Reset then async_i=4'b0001 held from edge 0 -> sync_o=4'b0001 after edge 6; rise_o=4'b0001 for that one cycle only.
REQ-030 async_i[1] high for 3 cycles then low -> sync_o[1] stays 0; rise_o/fall_o stay 0.
REQ-031 sync_o=4'b1111 then async_i=4'b0101 held -> fall_o=4'b1010 for one cycle, 6 edges after change; rise_o=0.
REQ-032 async_i[2] rises, rst_i pulsed 1 cycle at edge 4 with async_i held -> sync_o=0 after reset; sync_o[2] rises 6 edges after rst_i deasserts.
REQ-033 Filter macro undefined, async_i=4'b1000 -> sync_o=4'b1000 after edge 2; a 1-cycle glitch passes through as a 1-cycle sync_o pulse with rise_o and fall_o on consecutive cycles.

Source files
------------

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//
// Per-channel synchroniser for asynchronous level inputs, with an optional
// debounce filter and one-cycle edge-detect pulses on the resulting level.
//
// Optional feature macro: SYNC_DEBOUNCE_FILTER_EN
//   defined   : a channel's level is only accepted after the synchronised value
//               has differed from the current level for DEBOUNCE_CYCLES
//               consecutive cycles (latency STAGES + DEBOUNCE_CYCLES edges).
//   undefined : sync_o is the synchroniser output directly (latency STAGES
//               edges); DEBOUNCE_CYCLES has no effect and no counters exist.
//
// Parameters
//   WIDTH           number of independent channels (>= 1)
//   STAGES          synchroniser flop depth per channel (>= 2)
//   DEBOUNCE_CYCLES cycles a new value must persist before acceptance (>= 1)
//   RESET_VAL       per-channel reset level
//
// Ports
//   clk_i    single clock, all state on its rising edge
//   rst_i    synchronous, active-high reset
//   async_i  [WIDTH] asynchronous level inputs
//   sync_o   [WIDTH] synchronised (and optionally filtered) level
//   rise_o   [WIDTH] one-cycle pulse when sync_o goes 0->1
//   fall_o   [WIDTH] one-cycle pulse when sync_o goes 1->0
// -----------------------------------------------------------------------------
module sync_debounce #(
  parameter int               WIDTH           = 1,
  parameter int               STAGES          = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_debounce: WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_debounce: STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("sync_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync_p [STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_p1;

  // ---- synchroniser chain: async_i -> sync_p[0] .. sync_p[STAGES-1] ----
  // The chain is reset too, so that no pre-reset sample can be accepted
  // after reset is released.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_p[i] <= RESET_VAL;
      end
    end else begin
      sync_p[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_p[i] <= sync_p[i-1];
      end
    end
  end

  assign sync_s = sync_p[STAGES-1];

`ifdef SYNC_DEBOUNCE_FILTER_EN
  // ---- debounce filter: sync_s -> accepted level ----
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Counter advance; the accept branch resets the count at CNT_MAX, so this
  // saturation only guards against ever wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1'b1;
  endfunction

  for (genvar n = 0; n < WIDTH; n++) begin : g_chan
    logic [CNT_W-1:0] cnt;
    logic             acc;

    // cnt counts consecutive cycles of disagreement between the synchronised
    // sample and the accepted level; any agreement clears it, so a short
    // glitch leaves the accepted level alone.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt <= '0;
        acc <= RESET_VAL[n];
      end else if (sync_s[n] == acc) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        acc <= sync_s[n];
        cnt <= '0;
      end else begin
        cnt <= cnt_inc(cnt);
      end
    end

    assign level[n] = acc;
  end
`else
  assign level = sync_s;
`endif

  // ---- edge detect: level -> level_p1 ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_p1 <= RESET_VAL;
    end else begin
      level_p1 <= level;
    end
  end

  assign sync_o = level;
  assign rise_o = level & ~level_p1;
  assign fall_o = ~level & level_p1;

endmodule

// File: tb/tb_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce
//
// Directed scoreboard bench for sync_debounce (WIDTH=4, STAGES=2,
// DEBOUNCE_CYCLES=4, RESET_VAL=0). Expectations follow the filter macro
// SYNC_DEBOUNCE_FILTER_EN as seen by this compilation.
//
// The stimulus process drives async_i/rst_i and pushes hand-computed
// expectations into two queues:
//   ev_q : edge events (cycle, sync_o, rise_o, fall_o) expected whenever
//          rise_o or fall_o is non-zero
//   lv_q : quiet-cycle level checks at a given cycle
// The monitor process samples on the falling edge, pops and compares.
// -----------------------------------------------------------------------------
module tb_sync_debounce;

  localparam int WIDTH  = 4;
  localparam int STAGES = 2;
  localparam int DC     = 4;
`ifdef SYNC_DEBOUNCE_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = STAGES + DC;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = STAGES;
`endif
  localparam int MAX_CYC = 2000;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;

  sync_debounce #(
    .WIDTH          (WIDTH),
    .STAGES         (STAGES),
    .DEBOUNCE_CYCLES(DC),
    .RESET_VAL      (4'b0000)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(async_in),
    .sync_o (sync_out),
    .rise_o (rise_out),
    .fall_o (fall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] sync;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t ev_q[$];
  exp_t lv_q[$];
  bit   done = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic push_ev(input int c, input logic [3:0] s, input logic [3:0] r,
                         input logic [3:0] f);
    exp_t e;
    e.cyc = c; e.sync = s; e.rise = r; e.fall = f;
    ev_q.push_back(e);
  endtask

  task automatic push_lv(input int c, input logic [3:0] s, input logic [3:0] r,
                         input logic [3:0] f);
    exp_t e;
    e.cyc = c; e.sync = s; e.rise = r; e.fall = f;
    lv_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- monitor
  exp_t me;
  always @(negedge clk) begin
    if (lv_q.size() > 0 && lv_q[0].cyc <= cyc) begin
      me = lv_q.pop_front();
      n_tests++;
      if (me.cyc != cyc) begin
        n_fail++;
        $display("FAIL level_check_missed cyc=%0d required_cyc=%0d", cyc, me.cyc);
      end else if (sync_out !== me.sync || rise_out !== me.rise || fall_out !== me.fall) begin
        n_fail++;
        $display("FAIL level cyc=%0d got sync=%b rise=%b fall=%b required sync=%b rise=%b fall=%b",
                 cyc, sync_out, rise_out, fall_out, me.sync, me.rise, me.fall);
      end
    end

    if ((rise_out | fall_out) !== 4'b0000) begin
      n_tests++;
      if (ev_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_edge cyc=%0d got sync=%b rise=%b fall=%b required no pulse",
                 cyc, sync_out, rise_out, fall_out);
      end else begin
        me = ev_q.pop_front();
        if (me.cyc != cyc || sync_out !== me.sync || rise_out !== me.rise ||
            fall_out !== me.fall) begin
          n_fail++;
          $display("FAIL edge cyc=%0d got sync=%b rise=%b fall=%b required cyc=%0d sync=%b rise=%b fall=%b",
                   cyc, sync_out, rise_out, fall_out, me.cyc, me.sync, me.rise, me.fall);
        end
      end
    end

    if (done || cyc > MAX_CYC) begin
      n_tests++;
      if (!done) begin
        n_fail++;
        $display("FAIL timeout cyc=%0d limit=%0d", cyc, MAX_CYC);
      end else if (ev_q.size() != 0 || lv_q.size() != 0) begin
        n_fail++;
        $display("FAIL pending_expectations got events_left=%0d levels_left=%0d required 0 and 0",
                 ev_q.size(), lv_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // --------------------------------------------------------------- stimulus
  int k;
  initial begin
    rst      = 1'b1;
    async_in = 4'b0000;
    step(2);
    push_lv(cyc, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    step(2);

    // single channel rises; still low one cycle before the latency point
    k = cyc;
    async_in = 4'b0001;
    push_lv(k + LAT - 1, 4'b0000, 4'b0000, 4'b0000);
    push_ev(k + LAT, 4'b0001, 4'b0001, 4'b0000);
    step(LAT + 3);

    // channel 1 high for 3 cycles: rejected by the filter, passed otherwise
    k = cyc;
    async_in = 4'b0011;
    if (!FILT) begin
      push_ev(k + LAT,     4'b0011, 4'b0010, 4'b0000);
      push_ev(k + 3 + LAT, 4'b0001, 4'b0000, 4'b0010);
    end
    step(3);
    async_in = 4'b0001;
    step(LAT + 6);
    push_lv(cyc, 4'b0001, 4'b0000, 4'b0000);

    // all high, then 0101: fall pulse on channels 1 and 3 for one cycle
    k = cyc;
    async_in = 4'b1111;
    push_ev(k + LAT, 4'b1111, 4'b1110, 4'b0000);
    step(LAT + 3);
    k = cyc;
    async_in = 4'b0101;
    push_ev(k + LAT, 4'b0101, 4'b0000, 4'b1010);
    push_lv(k + LAT + 1, 4'b0101, 4'b0000, 4'b0000);
    step(LAT + 3);

    // back to zero, then channel 2 rises with a reset pulse mid-way
    k = cyc;
    async_in = 4'b0000;
    push_ev(k + LAT, 4'b0000, 4'b0000, 4'b0101);
    step(LAT + 3);
    k = cyc;
    async_in = 4'b0100;
    if (!FILT) push_ev(k + LAT, 4'b0100, 4'b0100, 4'b0000);
    step(3);
    rst = 1'b1;
    step(1);
    push_lv(cyc, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    push_ev(cyc + LAT, 4'b0100, 4'b0100, 4'b0000);
    step(LAT + 3);

    // one-cycle glitch on channel 3
    k = cyc;
    async_in = 4'b1100;
    step(1);
    async_in = 4'b0100;
    if (!FILT) begin
      push_ev(k + LAT,     4'b1100, 4'b1000, 4'b0000);
      push_ev(k + 1 + LAT, 4'b0100, 4'b0000, 4'b1000);
    end
    step(LAT + 4);
    push_lv(cyc, 4'b0100, 4'b0000, 4'b0000);

    // simultaneous rises and fall on different channels
    k = cyc;
    async_in = 4'b1011;
    push_ev(k + LAT, 4'b1011, 4'b1011, 4'b0100);
    step(LAT + 3);

    // channel 0 low for exactly DC cycles: accepted, then returns
    k = cyc;
    async_in = 4'b1010;
    push_ev(k + LAT,     4'b1010, 4'b0000, 4'b0001);
    push_ev(k + 4 + LAT, 4'b1011, 4'b0001, 4'b0000);
    step(4);
    async_in = 4'b1011;
    step(LAT + 4);

    done = 1'b1;
  end

endmodule
